// File: rtl/ring_allocator_pkg.sv
// Shared configuration for the ring allocator: default geometry and the
// allocation FSM state encoding.
package TauCfg;

  localparam int LBW_DEF       = 10;
  localparam int N_CFG_DEF     = 4;
  localparam int REC_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_EMIT,
    ST_NOTIFY
  } alloc_state_t;

endpackage

// File: rtl/ring_allocator_record_fifo.sv
// Outstanding-allocation record store: {config id, entry count} in allocation
// order, with same-cycle push and pop.
module alloc_record_fifo #(
  parameter int ID_W  = 3,
  parameter int SZ_W  = 11,
  parameter int DEPTH = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic [ID_W-1:0] i_push_id,
  input  logic [SZ_W-1:0] i_push_size,
  input  logic            i_pop,
  output logic [ID_W-1:0] o_head_id,
  output logic [SZ_W-1:0] o_head_size,
  output logic            o_full,
  output logic            o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ID_W+SZ_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_wr;
  logic [PW-1:0]        r_rd;
  logic [CW-1:0]        r_cnt;
  logic                 w_push;
  logic                 w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot a push into a full store needs.
  assign w_push  = i_push && (!o_full || w_pop);

  assign {o_head_id, o_head_size} = r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= {i_push_id, i_push_size};
  end

endmodule

// File: rtl/ring_allocator.sv
// Ring-buffer address allocator: reserves contiguous entry ranges per config,
// hands out start addresses, and releases them in allocation order.
module ring_allocator
  import TauCfg::*;
#(
  parameter int  LBW       = LBW_DEF,
  parameter int  N_CFG     = N_CFG_DEF,
  parameter int  REC_DEPTH = REC_DEPTH_DEF,
  localparam int ICFG_BW   = $clog2(N_CFG + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      alloc_rdy,
  output logic                      alloc_ack,
  input  logic [ICFG_BW-1:0]        i_beg_id,
  input  logic [ICFG_BW-1:0]        i_end_id,
  input  logic [N_CFG-1:0][LBW:0]   i_sizes,
  input  logic [N_CFG-1:0]          i_skip,
  output logic                      linear_rdy,
  input  logic                      linear_ack,
  output logic [LBW-1:0]            o_linear,
  output logic [ICFG_BW-1:0]        o_linear_id,
  output logic                      allocated_rdy,
  input  logic                      allocated_ack,
  input  logic                      free_dval,
  input  logic [ICFG_BW-1:0]        i_free_id,
  output logic [LBW:0]              o_used,
  output logic                      o_err
);

  localparam logic [LBW:0] RING_SIZE = {1'b1, {LBW{1'b0}}};

  alloc_state_t        r_state;
  alloc_state_t        w_state_nxt;
  logic [ICFG_BW-1:0]  r_cur;
  logic [ICFG_BW-1:0]  r_end;
  logic [LBW-1:0]      r_head;
  logic [LBW:0]        r_used;
  logic [LBW-1:0]      r_linear;
  logic [ICFG_BW-1:0]  r_linear_id;
  logic                r_err;

  logic [LBW:0]        w_size;
  logic [LBW:0]        w_space;
  logic [ICFG_BW-1:0]  w_cur_inc;
  logic                w_reserve;
  logic                w_pop;
  logic                w_free_err;
  logic [ICFG_BW-1:0]  w_head_id;
  logic [LBW:0]        w_head_size;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [LBW:0]        w_add;
  logic [LBW:0]        w_sub;

  alloc_record_fifo #(
    .ID_W  (ICFG_BW),
    .SZ_W  (LBW + 1),
    .DEPTH (REC_DEPTH)
  ) u_rec_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_reserve),
    .i_push_id   (r_cur),
    .i_push_size (w_size),
    .i_pop       (w_pop),
    .o_head_id   (w_head_id),
    .o_head_size (w_head_size),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  always_comb begin
    w_size = '0;
    for (int i = 0; i < N_CFG; i++) begin
      if (r_cur == ICFG_BW'(i)) w_size = i_skip[i] ? '0 : i_sizes[i];
    end
  end

  // Space check uses the registered occupancy; a same-cycle free only helps next cycle.
  assign w_space    = RING_SIZE - r_used;
  assign w_cur_inc  = r_cur + 1'b1;
  assign w_pop      = free_dval && !w_fifo_empty && (w_head_id == i_free_id);
  assign w_free_err = free_dval && !w_pop;
  assign w_reserve  = (r_state == ST_CHECK) && (w_space >= w_size) &&
                      (!w_fifo_full || w_pop);
  assign w_add      = w_reserve ? w_size : '0;
  assign w_sub      = w_pop ? w_head_size : '0;

  always_comb begin
    w_state_nxt   = r_state;
    alloc_ack     = 1'b0;
    linear_rdy    = 1'b0;
    allocated_rdy = 1'b0;
    case (r_state)
      ST_IDLE: begin
        alloc_ack = alloc_rdy;
        if (alloc_rdy) w_state_nxt = (i_beg_id < i_end_id) ? ST_CHECK : ST_NOTIFY;
      end
      ST_CHECK: begin
        if (w_reserve) w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        linear_rdy = 1'b1;
        if (linear_ack) w_state_nxt = (w_cur_inc == r_end) ? ST_NOTIFY : ST_CHECK;
      end
      ST_NOTIFY: begin
        allocated_rdy = 1'b1;
        if (allocated_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cur       <= '0;
      r_end       <= '0;
      r_head      <= '0;
      r_used      <= '0;
      r_linear    <= '0;
      r_linear_id <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && alloc_rdy) begin
        r_cur <= i_beg_id;
        r_end <= i_end_id;
      end else if (r_state == ST_EMIT && linear_ack) begin
        r_cur <= w_cur_inc;
      end
      if (w_reserve) begin
        r_linear    <= r_head;
        r_linear_id <= r_cur;
        r_head      <= r_head + w_size[LBW-1:0];
      end
      r_used <= r_used + w_add - w_sub;
      if (w_free_err) r_err <= 1'b1;
    end
  end

  assign o_linear    = r_linear;
  assign o_linear_id = r_linear_id;
  assign o_used      = r_used;
  assign o_err       = r_err;

endmodule

// File: tb/tb_ring_allocator.sv
// Directed bench for ring_allocator on a 16-entry ring with a 4-deep record store.
module tb_ring_allocator;

  localparam int LBW = 4;
  localparam int NC  = 4;
  localparam int RD  = 4;
  localparam int IW  = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  alloc_rdy;
  logic                  alloc_ack;
  logic [IW-1:0]         beg_id;
  logic [IW-1:0]         end_id;
  logic [NC-1:0][LBW:0]  sizes;
  logic [NC-1:0]         skip;
  logic                  linear_rdy;
  logic                  linear_ack;
  logic [LBW-1:0]        linear;
  logic [IW-1:0]         linear_id;
  logic                  allocated_rdy;
  logic                  allocated_ack;
  logic                  free_dval;
  logic [IW-1:0]         free_id;
  logic [LBW:0]          used;
  logic                  err;

  int n_vec = 0;
  int n_err = 0;

  ring_allocator #(.LBW(LBW), .N_CFG(NC), .REC_DEPTH(RD)) dut (
    .i_clk(clk), .i_rst(rst),
    .alloc_rdy(alloc_rdy), .alloc_ack(alloc_ack),
    .i_beg_id(beg_id), .i_end_id(end_id),
    .i_sizes(sizes), .i_skip(skip),
    .linear_rdy(linear_rdy), .linear_ack(linear_ack),
    .o_linear(linear), .o_linear_id(linear_id),
    .allocated_rdy(allocated_rdy), .allocated_ack(allocated_ack),
    .free_dval(free_dval), .i_free_id(free_id),
    .o_used(used), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic start_alloc(input logic [IW-1:0] b, input logic [IW-1:0] e);
    beg_id = b; end_id = e; alloc_rdy = 1'b1; tick(); alloc_rdy = 1'b0;
  endtask

  task automatic ack_linear();
    linear_ack = 1'b1; tick(); linear_ack = 1'b0;
  endtask

  task automatic ack_notify();
    allocated_ack = 1'b1; tick(); allocated_ack = 1'b0;
  endtask

  task automatic do_free(input logic [IW-1:0] id);
    free_dval = 1'b1; free_id = id; tick(); free_dval = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (linear_rdy !== 1'b0) begin n_err++; $display("FAIL rst_linear_rdy got %b want 0", linear_rdy); end
    n_vec++; if (allocated_rdy !== 1'b0) begin n_err++; $display("FAIL rst_allocated_rdy got %b want 0", allocated_rdy); end
    n_vec++; if (used !== 5'd0) begin n_err++; $display("FAIL rst_used got %0d want 0", used); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", err); end
    n_vec++; if (linear !== 4'd0 || linear_id !== 3'd0) begin n_err++; $display("FAIL rst_linear got %0d/%0d want 0/0", linear, linear_id); end
    n_vec++; if (alloc_ack !== 1'b0) begin n_err++; $display("FAIL rst_alloc_ack_idle got %b want 0", alloc_ack); end
    alloc_rdy = 1'b1; #1;
    n_vec++; if (alloc_ack !== 1'b1) begin n_err++; $display("FAIL idle_alloc_ack got %b want 1", alloc_ack); end
    alloc_rdy = 1'b0; #1;
  endtask

  task automatic test_alloc_stall();
    start_alloc(3'd0, 3'd3);
    n_vec++; if (linear_rdy !== 1'b0) begin n_err++; $display("FAIL lat_check_cycle got %b want 0", linear_rdy); end
    tick();
    n_vec++; if (linear_rdy !== 1'b1) begin n_err++; $display("FAIL lat_emit_cycle got %b want 1", linear_rdy); end
    n_vec++; if (linear !== 4'd0 || linear_id !== 3'd0) begin n_err++; $display("FAIL lin0 got %0d/%0d want 0/0", linear, linear_id); end
    n_vec++; if (used !== 5'd5) begin n_err++; $display("FAIL used0 got %0d want 5", used); end
    ack_linear();
    n_vec++; if (linear_rdy !== 1'b0) begin n_err++; $display("FAIL check_bubble got %b want 0", linear_rdy); end
    tick();
    n_vec++; if (linear !== 4'd5 || linear_id !== 3'd1) begin n_err++; $display("FAIL lin1 got %0d/%0d want 5/1", linear, linear_id); end
    n_vec++; if (used !== 5'd11) begin n_err++; $display("FAIL used1 got %0d want 11", used); end
    ack_linear();
    tick(); tick(); tick();
    n_vec++; if (linear_rdy !== 1'b0 || used !== 5'd11) begin n_err++; $display("FAIL stall got rdy=%b used=%0d want 0/11", linear_rdy, used); end
    do_free(3'd0);
    n_vec++; if (used !== 5'd6 || linear_rdy !== 1'b0) begin n_err++; $display("FAIL free_in_check got used=%0d rdy=%b want 6/0", used, linear_rdy); end
    tick();
    n_vec++; if (linear !== 4'd11 || linear_id !== 3'd2 || linear_rdy !== 1'b1) begin n_err++; $display("FAIL lin2 got %0d/%0d rdy=%b want 11/2/1", linear, linear_id, linear_rdy); end
    n_vec++; if (used !== 5'd13) begin n_err++; $display("FAIL used2 got %0d want 13", used); end
    ack_linear();
    n_vec++; if (allocated_rdy !== 1'b1) begin n_err++; $display("FAIL notify got %b want 1", allocated_rdy); end
    ack_notify();
    n_vec++; if (allocated_rdy !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL back_idle got arb=%b err=%b want 0/0", allocated_rdy, err); end
  endtask

  task automatic test_free_err();
    do_free(3'd2);
    n_vec++; if (err !== 1'b1 || used !== 5'd13) begin n_err++; $display("FAIL wrong_id got err=%b used=%0d want 1/13", err, used); end
    do_free(3'd1);
    n_vec++; if (err !== 1'b1 || used !== 5'd7) begin n_err++; $display("FAIL sticky got err=%b used=%0d want 1/7", err, used); end
    do_free(3'd2);
    n_vec++; if (used !== 5'd0) begin n_err++; $display("FAIL free_last got %0d want 0", used); end
    apply_reset();
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_cleared got %b want 0", err); end
    do_free(3'd0);
    n_vec++; if (err !== 1'b1 || used !== 5'd0) begin n_err++; $display("FAIL empty_free got err=%b used=%0d want 1/0", err, used); end
    apply_reset();
  endtask

  task automatic test_skip();
    start_alloc(3'd0, 3'd1); tick(); ack_linear(); ack_notify();
    skip = 4'b1000;
    start_alloc(3'd3, 3'd4); tick();
    n_vec++; if (linear_rdy !== 1'b1 || linear !== 4'd5 || linear_id !== 3'd3) begin n_err++; $display("FAIL skip_lin got rdy=%b %0d/%0d want 1 5/3", linear_rdy, linear, linear_id); end
    n_vec++; if (used !== 5'd5) begin n_err++; $display("FAIL skip_used got %0d want 5", used); end
    ack_linear(); ack_notify();
    do_free(3'd0);
    do_free(3'd3);
    n_vec++; if (used !== 5'd0 || err !== 1'b0) begin n_err++; $display("FAIL skip_free got used=%0d err=%b want 0/0", used, err); end
    skip = 4'b0000;
  endtask

  task automatic test_simultaneous();
    sizes = {5'd0, 5'd4, 5'd7, 5'd5};
    start_alloc(3'd0, 3'd2); tick(); ack_linear(); tick();
    n_vec++; if (used !== 5'd12 || linear !== 4'd10) begin n_err++; $display("FAIL sim_setup got used=%0d lin=%0d want 12/10", used, linear); end
    ack_linear(); ack_notify();
    start_alloc(3'd2, 3'd3);
    free_dval = 1'b1; free_id = 3'd0; tick(); free_dval = 1'b0;
    n_vec++; if (used !== 5'd11) begin n_err++; $display("FAIL sim_used got %0d want 11", used); end
    n_vec++; if (linear_rdy !== 1'b1 || linear !== 4'd1 || linear_id !== 3'd2) begin n_err++; $display("FAIL sim_wrap_lin got rdy=%b %0d/%0d want 1 1/2", linear_rdy, linear, linear_id); end
    ack_linear(); ack_notify();
    do_free(3'd1); do_free(3'd2);
    n_vec++; if (used !== 5'd0 || err !== 1'b0) begin n_err++; $display("FAIL sim_drain got used=%0d err=%b want 0/0", used, err); end
    sizes = {5'd0, 5'd7, 5'd6, 5'd5};
  endtask

  task automatic test_hold_and_empty();
    start_alloc(3'd0, 3'd1); tick();
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (linear_rdy !== 1'b1 || linear !== 4'd5) begin n_err++; $display("FAIL hold_%0d got rdy=%b lin=%0d want 1/5", i, linear_rdy, linear); end
      tick();
    end
    ack_linear(); ack_notify();
    start_alloc(3'd2, 3'd2);
    n_vec++; if (allocated_rdy !== 1'b1 || linear_rdy !== 1'b0) begin n_err++; $display("FAIL empty_range got arb=%b lrdy=%b want 1/0", allocated_rdy, linear_rdy); end
    n_vec++; if (used !== 5'd5) begin n_err++; $display("FAIL empty_used got %0d want 5", used); end
    ack_notify();
    do_free(3'd0);
  endtask

  task automatic test_full_fifo();
    sizes = {5'd1, 5'd1, 5'd1, 5'd1};
    start_alloc(3'd0, 3'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (linear !== 4'(10 + i)) begin n_err++; $display("FAIL fill_%0d got %0d want %0d", i, linear, 10 + i); end
      ack_linear();
    end
    ack_notify();
    start_alloc(3'd0, 3'd1); tick();
    n_vec++; if (linear_rdy !== 1'b0 || used !== 5'd4) begin n_err++; $display("FAIL full_stall got rdy=%b used=%0d want 0/4", linear_rdy, used); end
    do_free(3'd0);
    n_vec++; if (linear_rdy !== 1'b1 || linear !== 4'd14 || used !== 5'd4) begin n_err++; $display("FAIL full_free got rdy=%b lin=%0d used=%0d want 1/14/4", linear_rdy, linear, used); end
    ack_linear(); ack_notify();
    do_free(3'd1); do_free(3'd2); do_free(3'd3); do_free(3'd0);
    n_vec++; if (used !== 5'd0 || err !== 1'b0) begin n_err++; $display("FAIL full_drain got used=%0d err=%b want 0/0", used, err); end
  endtask

  task automatic test_reset_mid();
    start_alloc(3'd0, 3'd1); tick();
    n_vec++; if (linear_rdy !== 1'b1 || linear !== 4'd15) begin n_err++; $display("FAIL mid_pre got rdy=%b lin=%0d want 1/15", linear_rdy, linear); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_vec++; if (linear_rdy !== 1'b0 || used !== 5'd0 || linear !== 4'd0) begin n_err++; $display("FAIL mid_rst got rdy=%b used=%0d lin=%0d want 0/0/0", linear_rdy, used, linear); end
    start_alloc(3'd0, 3'd1); tick();
    n_vec++; if (linear_rdy !== 1'b1 || linear !== 4'd0 || used !== 5'd1) begin n_err++; $display("FAIL mid_fresh got rdy=%b lin=%0d used=%0d want 1/0/1", linear_rdy, linear, used); end
    ack_linear(); ack_notify();
    do_free(3'd0);
    n_vec++; if (used !== 5'd0 || err !== 1'b0) begin n_err++; $display("FAIL mid_free got used=%0d err=%b want 0/0", used, err); end
  endtask

  task automatic test_wrap_full();
    sizes = {5'd1, 5'd1, 5'd6, 5'd16};
    start_alloc(3'd0, 3'd1); tick();
    n_vec++; if (linear_rdy !== 1'b1 || linear !== 4'd1 || used !== 5'd16) begin n_err++; $display("FAIL whole_ring got rdy=%b lin=%0d used=%0d want 1/1/16", linear_rdy, linear, used); end
    ack_linear(); ack_notify();
    start_alloc(3'd1, 3'd2); tick(); tick();
    n_vec++; if (linear_rdy !== 1'b0 || used !== 5'd16) begin n_err++; $display("FAIL ring_full got rdy=%b used=%0d want 0/16", linear_rdy, used); end
    do_free(3'd0);
    n_vec++; if (used !== 5'd0 || linear_rdy !== 1'b0) begin n_err++; $display("FAIL ring_freed got used=%0d rdy=%b want 0/0", used, linear_rdy); end
    tick();
    n_vec++; if (linear_rdy !== 1'b1 || linear !== 4'd1 || used !== 5'd6) begin n_err++; $display("FAIL after_wrap got rdy=%b lin=%0d used=%0d want 1/1/6", linear_rdy, linear, used); end
    ack_linear(); ack_notify();
    do_free(3'd1);
  endtask

  initial begin
    rst = 1'b0; alloc_rdy = 1'b0; beg_id = '0; end_id = '0;
    sizes = {5'd0, 5'd7, 5'd6, 5'd5}; skip = '0;
    linear_ack = 1'b0; allocated_ack = 1'b0; free_dval = 1'b0; free_id = '0;
    test_reset();
    test_alloc_stall();
    test_free_err();
    test_skip();
    test_simultaneous();
    test_hold_and_empty();
    test_full_fifo();
    test_reset_mid();
    test_wrap_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ring_allocator.md
RING_ALLOCATOR -- requirements
Module: ring_allocator

Interface
REQ-001 Parameter LBW, default 10, local address width; the ring holds 2^LBW vector entries.
REQ-002 Parameter N_CFG, default 4, number of input configs; ICFG_BW = $clog2(N_CFG+1).
REQ-003 Parameter REC_DEPTH, default 16, power of two, maximum number of outstanding allocation records.
REQ-004 i_clk  in  1  clock; i_rst  in  1  reset, synchronous, active-high.
REQ-005 alloc_rdy  in  1 / alloc_ack  out  1  request handshake for allocating one config range.
REQ-006 i_beg_id, i_end_id  in  ICFG_BW  half-open config range [beg, end), sampled on alloc_ack.
REQ-007 i_sizes  in  [N_CFG][LBW+1]  static per-config entry count; i_skip  in  N_CFG  static zero-size mask.
REQ-008 linear_rdy  out  1 / linear_ack  in  1  one start address per config; o_linear  out  LBW; o_linear_id  out  ICFG_BW.
REQ-009 allocated_rdy  out  1 / allocated_ack  in  1  notifies DMA that the whole range is reserved.
REQ-010 free_dval  in  1; i_free_id  in  ICFG_BW  releases the oldest record.
REQ-011 o_used  out  LBW+1  occupied entries; o_err  out  1  sticky protocol error.

Function
REQ-012 Any handshake SHALL transfer in a cycle where rdy&&ack; rdy, once raised, SHALL hold with stable data until the ack.
REQ-013 FSM states SHALL be IDLE, CHECK, EMIT, NOTIFY; alloc_ack SHALL equal alloc_rdy in IDLE and be 0 elsewhere.
REQ-014 IDLE plus alloc_ack: latch beg/end, cur=beg; next state CHECK if beg<end, else NOTIFY.
REQ-015 CHECK: size = i_skip[cur] ? 0 : i_sizes[cur]; reserve only if (2^LBW - used) >= size and the record FIFO is not full; otherwise stay in CHECK.
REQ-016 Reserve action (single cycle): o_linear<=head, o_linear_id<=cur, head<=(head+size) mod 2^LBW, push {cur,size}, used+=size, next state EMIT.
REQ-017 EMIT: linear_rdy=1; on ack, cur++, go to NOTIFY if cur+1==end, else CHECK.
REQ-018 NOTIFY: allocated_rdy=1; on ack, go to IDLE.
REQ-019 Latency: alloc_ack to first linear_rdy SHALL be exactly 2 cycles when space is available; there are no bubbles other than CHECK.
REQ-020 Free: on free_dval, if the FIFO is non-empty and its head id == i_free_id, pop and subtract the head size from used; otherwise set o_err and change nothing else.
REQ-021 Simultaneous reserve and free: used <= used + size_alloc - size_free in one cycle; the CHECK comparison SHALL use the registered used.
REQ-022 A zero-size (skipped) config SHALL still emit a linear and push a record, so frees stay paired.
REQ-023 Allocations MAY wrap past 2^LBW-1; the consumer SHALL address modulo 2^LBW.
REQ-024 size == 2^LBW SHALL succeed only when used == 0; used SHALL never exceed 2^LBW.
REQ-025 A free arriving while the FIFO is full SHALL be honoured, making room in the same cycle.

Reset
REQ-026 On i_rst the block SHALL enter IDLE with head=0, used=0, FIFO empty, o_err=0, linear_rdy=0, allocated_rdy=0, o_linear=0, o_linear_id=0.
REQ-027 Reset mid-operation SHALL drop all outstanding records and any pending handshake; the next cycle SHALL match the post-reset state.

Structure
REQ-028 Default LBW, N_CFG, REC_DEPTH and the FSM state enum SHALL live in TauCfg; ICFG_BW SHALL be derived locally.
REQ-029 The record store SHALL be one sub-module, alloc_record_fifo (REC_DEPTH x {ICFG_BW, LBW+1}), with same-cycle push/pop.

Verification
REQ-030 Case: LBW=4, sizes={5,6,7,0}, range [0,3) -> linears 0,5,11 with ids 0,1,2; used=18?! Not allowed: 7 does not fit after 11, so id2 stalls in CHECK until a free of id0, then linear=11 and used=13.
REQ-031 Case: i_skip[3]=1, range [3,4) -> linear=head, used unchanged, one record pushed; free id3 -> used unchanged, o_err=0.
REQ-032 Case: free_dval with i_free_id=2 while the oldest record is id0 -> o_err=1 and sticky, used unchanged; FIFO empty plus free -> o_err=1.
REQ-033 Case: same-cycle reserve of size 4 and free of size 5 at used=12 -> used=11 next cycle.
REQ-034 Case: linear_ack held low 10 cycles -> o_linear stable; range [2,2) -> allocated_rdy 1 cycle after ack, no linear emitted.
REQ-035 Case: i_rst pulsed during EMIT -> linear_rdy=0 and used=0 next cycle; a fresh request then starts at linear 0.
